mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single RAM port between instruction fetch (I) and data access (D) requesters.
//  Sits between the datapath (PC fetch path / MemRead-MemWrite path) and RAM.
//  Registered FSM with D-over-I priority, I-starvation guard and RAM-ready timeout.
// PARAMETERS
//  MAX_DBURST  4   consecutive D completions allowed while iREN pending before I is forced
//  TIMEOUT     64  cycles in a grant state without ram_ready before abort + err pulse
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RST       in   1   synchronous, active-high reset
//  iREN      in   1   instruction read request (level, held until iwait low)
//  iaddr     in   32  instruction address
//  iwait     out  1   0 only in the cycle the I read completes
//  iload     out  32  instruction word; valid when iwait==0
//  dREN      in   1   data read request (level)
//  dWEN      in   1   data write request (level); wins over dREN if both high
//  daddr     in   32  data address
//  dstore    in   32  write data
//  dwait     out  1   0 only in the cycle the D access completes
//  dload     out  32  read data; valid when dwait==0 and dREN
//  ramREN    out  1   RAM read strobe
//  ramWEN    out  1   RAM write strobe
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ram_ready in   1   RAM completes access this cycle
//  err       out  1   1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (RST high at edge): state=IDLE, dcount=0, tcount=0; while in IDLE: ramREN=ramWEN=0,
//   ramaddr=0, ramstore=0, iwait=dwait=1, err=0. RST mid-transaction aborts with no completion.
//  States: IDLE, DGRANT, IGRANT. RAM outputs are combinational from state + granted requester.
//  IDLE: drives no RAM strobe. Next: if (dREN|dWEN) and !(iREN && dcount==MAX_DBURST) -> DGRANT;
//   else if iREN -> IGRANT; else IDLE.
//  DGRANT: ramaddr=daddr; dWEN -> ramWEN=1, ramstore=dstore; else ramREN=1. On ram_ready:
//   dwait=0, dload=ramload, -> IDLE. If dREN|dWEN drops before ram_ready: strobes low, -> IDLE.
//  IGRANT: ramREN=1, ramaddr=iaddr. On ram_ready: iwait=0, iload=ramload, -> IDLE.
//   iREN drops early -> IDLE, no completion.
//  Latency: request seen in IDLE at edge N, RAM strobe from cycle N+1, earliest completion N+1;
//   back-to-back grants separated by one IDLE cycle.
//  iload/dload = ramload passthrough; contents undefined while matching wait==1.
//  dcount (width clog2(MAX_DBURST+1)): +1 on each D completion with iREN high, saturates at
//   MAX_DBURST; cleared on I completion or any cycle iREN==0.
//  tcount: cleared on entry to a grant state; +1 each grant cycle without ram_ready; on reaching
//   TIMEOUT-1 without ready: err=1 for that cycle, strobes low next cycle, -> IDLE, wait stays 1.
//  ram_ready seen in IDLE is ignored. Only one of ramREN/ramWEN high in any cycle.
// TESTING
//  1 RST held 2 cycles with iREN=dREN=1 -> ramREN=ramWEN=0, iwait=dwait=1, err=0 throughout.
//  2 iREN=1, iaddr=0x40, ram_ready 3 cycles after strobe -> ramaddr=0x40, iwait=0 one cycle, iload=ramload.
//  3 iREN and dWEN=1 same cycle, daddr=0x100, dstore=0xDEADBEEF -> D first (ramWEN=1), then I grant.
//  4 dREN held continuously with iREN, ram_ready immediate, MAX_DBURST=4 -> 4 D completions then 1 I.
//  5 dREN=1, ram_ready never -> err pulses at grant cycle TIMEOUT-1, FSM to IDLE, dwait stays 1.
//  6 dREN dropped mid-grant -> strobes low next cycle, no dwait=0, FSM returns IDLE then grants I if pending.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access requesters.
// D has priority over I, with a burst limit that forces I through and a RAM-ready timeout.
module mem_arbiter #(
  parameter int unsigned MAX_DBURST = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        err
);

  localparam int unsigned DCW = $clog2(MAX_DBURST + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [DCW-1:0] dcount_q, dcount_d;
  logic [TCW-1:0] tcount_q, tcount_d;

  logic d_req, d_act, i_act, d_done, i_done, tmo, i_forced;

  // Grant qualifiers: a grant only drives RAM while its requester still asks.
  always_comb begin
    d_req    = dREN | dWEN;
    d_act    = (state_q == DGRANT) && !RST && d_req;
    i_act    = (state_q == IGRANT) && !RST && iREN;
    d_done   = d_act && ram_ready;
    i_done   = i_act && ram_ready;
    tmo      = (d_act || i_act) && !ram_ready && (tcount_q == TCW'(TIMEOUT - 1));
    i_forced = iREN && (dcount_q == DCW'(MAX_DBURST));
  end

  always_comb begin
    ramREN   = i_act | (d_act & ~dWEN);
    ramWEN   = d_act & dWEN;
    ramstore = ramWEN ? dstore : 32'h0;
    ramaddr  = 32'h0;
    if (state_q == DGRANT)      ramaddr = daddr;
    else if (state_q == IGRANT) ramaddr = iaddr;
    iwait    = ~i_done;
    dwait    = ~d_done;
    iload    = ramload;
    dload    = ramload;
    err      = tmo;
  end

  always_comb begin
    state_d  = state_q;
    dcount_d = dcount_q;
    tcount_d = (state_q == IDLE) ? '0 : tcount_q + TCW'(1);
    case (state_q)
      IDLE: begin
        if (d_req && !i_forced) state_d = DGRANT;
        else if (iREN)          state_d = IGRANT;
      end
      DGRANT: if (!d_req || ram_ready || tmo) state_d = IDLE;
      IGRANT: if (!iREN || ram_ready || tmo)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Burst counter only tracks D completions that made I wait.
    if (!iREN || i_done)
      dcount_d = '0;
    else if (d_done && (dcount_q != DCW'(MAX_DBURST)))
      dcount_d = dcount_q + DCW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      dcount_q <= '0;
      tcount_q <= '0;
    end else begin
      state_q  <= state_d;
      dcount_q <= dcount_d;
      tcount_q <= tcount_d;
    end
  end

endmodule
